// File: rtl/jtcontra_gfx_romarb_if.sv
// Bus bundle for jtcontra_gfx_romarb: client request/response channels on one
// side, the single shared SDRAM read slot on the other.
// slave  : the arbiter's view
// master : the view of whoever drives the clients and the SDRAM model
interface jtcontra_gfx_romarb_if #(
    parameter int CH = 2,
    parameter int AW = 18,
    parameter int DW = 16
);
    logic [CH-1:0]    en;
    logic [CH-1:0]    req_cs;
    logic [CH*AW-1:0] req_addr;
    logic [CH-1:0]    req_ok;
    logic [CH*DW-1:0] req_data;
    logic             rom_cs;
    logic [AW-1:0]    rom_addr;
    logic             rom_ok;
    logic [DW-1:0]    rom_data;
    logic             busy;
    logic             tout_err;

    modport slave (
        input  en, req_cs, req_addr, rom_ok, rom_data,
        output req_ok, req_data, rom_cs, rom_addr, busy, tout_err
    );

    modport master (
        output en, req_cs, req_addr, rom_ok, rom_data,
        input  req_ok, req_data, rom_cs, rom_addr, busy, tout_err
    );
endinterface

// File: rtl/jtcontra_gfx_romarb.sv
// SDRAM read arbiter for the 007121-class graphics pipeline. CH clients share
// one SDRAM slot; fixed (RR=0) or round-robin (RR=1) priority, per-channel
// enable gating (disabled channels get zero data without touching SDRAM) and
// invalidation of delivered data when a client changes its address.
// Optional build macro JTCONTRA_GFX_ROMARB_TIMEOUT_EN: abort a slot after TOUT
// cycles without rom_ok, set sticky tout_err and retry the request.
//
// state | meaning
// IDLE  | no slot in flight, pick a winner among pending channels
// WAIT1 | rom_cs just raised; any rom_ok now belongs to the previous slot
// BUSY  | waiting for rom_ok for channel sel
module jtcontra_gfx_romarb #(
    parameter int CH   = 2,
    parameter int AW   = 18,
    parameter int DW   = 16,
    parameter int RR   = 0,
    parameter int TOUT = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    jtcontra_gfx_romarb_if.slave   bus
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    if (CH < 1 || CH > 8 || TOUT < 1) begin : g_bad_param
        $error("jtcontra_gfx_romarb: CH must be 1..8 and TOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT1, BUSY} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [SW-1:0] last_grant;
    logic [SW-1:0] win;
    logic          any_pend;
    logic          found;
    logic [SW:0]   rr_sum;
    logic [SW-1:0] rr_cand;
    logic [CH-1:0] pending;
    logic [AW-1:0] lat_addr [CH];

`ifdef JTCONTRA_GFX_ROMARB_TIMEOUT_EN
    localparam int CW = $clog2(TOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign bus.tout_err = 1'b0;
`endif

    assign bus.busy = (state != IDLE);

    // A channel wants SDRAM when it requests, is enabled, holds no valid data
    // and is not the one already being served.
    always_comb begin
        pending = '0;
        for (int i = 0; i < CH; i++) begin
            pending[i] = bus.req_cs[i] & bus.en[i] & ~bus.req_ok[i]
                       & ~(bus.busy && sel == SW'(i));
        end
    end

    // Winner selection: lowest index, or first pending after last_grant with wrap.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        rr_sum   = '0;
        rr_cand  = '0;
        any_pend = |pending;
        if (RR == 0) begin
            for (int i = CH - 1; i >= 0; i--) begin
                if (pending[i]) win = SW'(i);
            end
        end else begin
            for (int k = 1; k <= CH; k++) begin
                rr_sum = {1'b0, last_grant} + (SW+1)'(k);
                if (rr_sum >= (SW+1)'(CH)) rr_sum = rr_sum - (SW+1)'(CH);
                rr_cand = rr_sum[SW-1:0];
                if (!found && pending[rr_cand]) begin
                    win   = rr_cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Per-channel invalidation / disabled-channel bypass plus the slot FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= '0;
            last_grant   <= SW'(CH - 1);
            bus.rom_cs   <= 1'b0;
            bus.rom_addr <= '0;
            bus.req_ok   <= '0;
            bus.req_data <= '0;
            for (int i = 0; i < CH; i++) lat_addr[i] <= '0;
`ifdef JTCONTRA_GFX_ROMARB_TIMEOUT_EN
            cnt          <= '0;
            bus.tout_err <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!bus.req_cs[i]) begin
                    bus.req_ok[i] <= 1'b0;
                end else if (bus.req_ok[i] && bus.req_addr[i*AW +: AW] != lat_addr[i]) begin
                    bus.req_ok[i] <= 1'b0;
                end else if (!bus.en[i] && !bus.req_ok[i] && !(bus.busy && sel == SW'(i))) begin
                    // the channel being served keeps its slot even if en drops
                    bus.req_ok[i]             <= 1'b1;
                    bus.req_data[i*DW +: DW]  <= '0;
                    lat_addr[i]               <= bus.req_addr[i*AW +: AW];
                end
            end

            case (state)
                IDLE: begin
                    if (any_pend) begin
                        bus.rom_cs    <= 1'b1;
                        bus.rom_addr  <= bus.req_addr[int'(win)*AW +: AW];
                        lat_addr[win] <= bus.req_addr[int'(win)*AW +: AW];
                        sel           <= win;
                        last_grant    <= win;
                        state         <= WAIT1;
`ifdef JTCONTRA_GFX_ROMARB_TIMEOUT_EN
                        cnt           <= '0;
`endif
                    end
                end
                WAIT1: begin
                    state <= BUSY;
`ifdef JTCONTRA_GFX_ROMARB_TIMEOUT_EN
                    cnt   <= cnt + 1'b1;
`endif
                end
                BUSY: begin
                    if (bus.rom_ok) begin
                        // data is only good if the client still wants this address
                        if (bus.req_cs[sel] && bus.req_addr[int'(sel)*AW +: AW] == lat_addr[sel]) begin
                            bus.req_data[int'(sel)*DW +: DW] <= bus.rom_data;
                            bus.req_ok[sel]                  <= 1'b1;
                        end
                        bus.rom_cs <= 1'b0;
                        state      <= IDLE;
                    end
`ifdef JTCONTRA_GFX_ROMARB_TIMEOUT_EN
                    else if (cnt >= CW'(TOUT - 1)) begin
                        bus.rom_cs   <= 1'b0;
                        bus.tout_err <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
